// File: rtl/rv32i_regfile.sv
// RV32I 32 x XLEN integer register file with a per-register pending-write scoreboard.
// Latency: reads and busy flags are combinational; writes and scoreboard updates land on the rising edge.
// Backpressure: none; decode stalls itself on the busy flags, and the sticky sb_err flags over/underflow.
module rv32i_regfile #(
  parameter int XLEN   = 32,
  parameter int CNT_W  = 2,
  parameter int BYPASS = 1
) (
  input  logic            i_clk,
  input  logic            i_reset,     // asynchronous, active-low
  input  logic [4:0]      i_rs1_reg,
  input  logic [4:0]      i_rs2_reg,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  output logic            o_rs1_busy,
  output logic            o_rs2_busy,
  input  logic            i_iss_en,
  input  logic [4:0]      i_iss_reg,
  input  logic            i_wb_en,
  input  logic [4:0]      i_wb_reg,
  input  logic [XLEN-1:0] i_wb_data,
  output logic            o_sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Entry 0 is held at reset value forever, so x0 reads zero and never looks busy.
  logic [XLEN-1:0]  r_regs [0:31];
  logic [CNT_W-1:0] r_cnt  [0:31];
  logic             r_sb_err;

  logic             w_fwd1;
  logic             w_fwd2;
  logic [CNT_W-1:0] w_cnt1;
  logic [CNT_W-1:0] w_cnt2;

  // Register array: writeback commits on the edge, x0 writes are dropped.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (i_wb_en && (i_wb_reg == i[4:0])) r_regs[i] <= i_wb_data;
      end
    end
  end

  // Scoreboard: issue increments, writeback decrements, both together cancel; saturate and flag on misuse.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < 32; i++) r_cnt[i] <= '0;
      r_sb_err <= 1'b0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (i_iss_en && (i_iss_reg == i[4:0]) && !(i_wb_en && (i_wb_reg == i[4:0]))) begin
          if (r_cnt[i] == CNT_MAX) r_sb_err <= 1'b1;
          else                     r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end else if (i_wb_en && (i_wb_reg == i[4:0]) && !(i_iss_en && (i_iss_reg == i[4:0]))) begin
          if (r_cnt[i] == CNT_ZERO) r_sb_err <= 1'b1;
          else                      r_cnt[i] <= r_cnt[i] - CNT_ONE;
        end
      end
    end
  end

  // Read ports: writeback data is forwarded when bypass is enabled and the address matches.
  always_comb begin
    w_fwd1 = (BYPASS != 0) && i_wb_en && (i_wb_reg == i_rs1_reg) && (i_rs1_reg != 5'd0);
    w_fwd2 = (BYPASS != 0) && i_wb_en && (i_wb_reg == i_rs2_reg) && (i_rs2_reg != 5'd0);
    w_cnt1 = r_cnt[i_rs1_reg];
    w_cnt2 = r_cnt[i_rs2_reg];

    if (i_rs1_reg == 5'd0) o_rs1_data = '0;
    else if (w_fwd1)       o_rs1_data = i_wb_data;
    else                   o_rs1_data = r_regs[i_rs1_reg];

    if (i_rs2_reg == 5'd0) o_rs2_data = '0;
    else if (w_fwd2)       o_rs2_data = i_wb_data;
    else                   o_rs2_data = r_regs[i_rs2_reg];

    // The last outstanding write being forwarded this cycle is no longer a hazard.
    o_rs1_busy = (i_rs1_reg != 5'd0) && (w_cnt1 != CNT_ZERO) && !(w_fwd1 && (w_cnt1 == CNT_ONE));
    o_rs2_busy = (i_rs2_reg != 5'd0) && (w_cnt2 != CNT_ZERO) && !(w_fwd2 && (w_cnt2 == CNT_ONE));
  end

  assign o_sb_err = r_sb_err;

endmodule

// File: tb/tb_rv32i_regfile.sv
// Directed bench for rv32i_regfile: a BYPASS=1 and a BYPASS=0 instance share one stimulus stream.
module tb_rv32i_regfile;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_reg, rs2_reg, iss_reg, wb_reg;
  logic        iss_en, wb_en;
  logic [31:0] wb_data;

  logic [31:0] d1, d2, d1_nb, d2_nb;
  logic        b1, b2, err, b1_nb, b2_nb, err_nb;

  int n_pass  = 0;
  int n_total = 0;

  rv32i_regfile #(.XLEN(32), .CNT_W(2), .BYPASS(1)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_rs1_reg(rs1_reg), .i_rs2_reg(rs2_reg),
    .o_rs1_data(d1), .o_rs2_data(d2),
    .o_rs1_busy(b1), .o_rs2_busy(b2),
    .i_iss_en(iss_en), .i_iss_reg(iss_reg),
    .i_wb_en(wb_en), .i_wb_reg(wb_reg), .i_wb_data(wb_data),
    .o_sb_err(err)
  );

  rv32i_regfile #(.XLEN(32), .CNT_W(2), .BYPASS(0)) dut_nb (
    .i_clk(clk), .i_reset(rst_n),
    .i_rs1_reg(rs1_reg), .i_rs2_reg(rs2_reg),
    .o_rs1_data(d1_nb), .o_rs2_data(d2_nb),
    .o_rs1_busy(b1_nb), .o_rs2_busy(b2_nb),
    .i_iss_en(iss_en), .i_iss_reg(iss_reg),
    .i_wb_en(wb_en), .i_wb_reg(wb_reg), .i_wb_data(wb_data),
    .o_sb_err(err_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        iss_en;
    logic [4:0]  iss_reg;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic [31:0] e_d1;
    logic [31:0] e_d2;
    logic        e_b1;
    logic        e_b2;
    logic        e_err;
    logic [31:0] e_d1_nb;
    logic        e_b1_nb;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Apply one cycle of inputs just after the rising edge, then return at the falling edge for sampling.
  task automatic drive(input logic [4:0] r1, input logic [4:0] r2,
                       input logic ie, input logic [4:0] ir,
                       input logic we, input logic [4:0] wr, input logic [31:0] wd);
    @(posedge clk);
    #1;
    rs1_reg = r1; rs2_reg = r2;
    iss_en = ie; iss_reg = ir;
    wb_en = we; wb_reg = wr; wb_data = wd;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    rs1_reg = '0; rs2_reg = '0; iss_en = 1'b0; iss_reg = '0;
    wb_en = 1'b0; wb_reg = '0; wb_data = '0;

    //            rs1 rs2 ie ir we wr wdata          d1           d2           b1 b2 err d1_nb        b1_nb
    vecs[0]  = '{5,  5,  1, 5, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 32'h0,        0};
    vecs[1]  = '{5,  5,  0, 0, 1, 5, 32'h12345678, 32'h12345678, 32'h12345678, 0, 0, 0, 32'h0,        1};
    vecs[2]  = '{5,  0,  0, 0, 0, 0, 32'h0,        32'h12345678, 32'h0,        0, 0, 0, 32'h12345678, 0};
    vecs[3]  = '{0,  0,  1, 0, 1, 0, 32'hFFFFFFFF, 32'h0,        32'h0,        0, 0, 0, 32'h0,        0};
    vecs[4]  = '{0,  0,  0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 32'h0,        0};
    vecs[5]  = '{7,  7,  1, 7, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 32'h0,        0};
    vecs[6]  = '{0,  7,  1, 7, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 0, 32'h0,        0};
    vecs[7]  = '{7,  7,  0, 0, 1, 7, 32'hA,        32'hA,        32'hA,        1, 1, 0, 32'h0,        1};
    vecs[8]  = '{7,  7,  0, 0, 1, 7, 32'hB,        32'hB,        32'hB,        0, 0, 0, 32'hA,        1};
    vecs[9]  = '{7,  7,  0, 0, 0, 0, 32'h0,        32'hB,        32'hB,        0, 0, 0, 32'hB,        0};
    vecs[10] = '{9,  0,  1, 9, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 32'h0,        0};
    vecs[11] = '{9,  0,  1, 9, 1, 9, 32'h99,       32'h99,       32'h0,        0, 0, 0, 32'h0,        1};
    vecs[12] = '{9,  0,  0, 0, 0, 0, 32'h0,        32'h99,       32'h0,        1, 0, 0, 32'h99,       1};
    vecs[13] = '{9,  0,  0, 0, 1, 9, 32'h98,       32'h98,       32'h0,        0, 0, 0, 32'h99,       1};
    vecs[14] = '{9,  0,  0, 0, 0, 0, 32'h0,        32'h98,       32'h0,        0, 0, 0, 32'h98,       0};
    vecs[15] = '{3,  0,  0, 0, 1, 3, 32'h33,       32'h33,       32'h0,        0, 0, 0, 32'h0,        0};
    vecs[16] = '{3,  0,  0, 0, 0, 0, 32'h0,        32'h33,       32'h0,        0, 0, 1, 32'h33,       0};
    vecs[17] = '{3,  5,  0, 0, 0, 0, 32'h0,        32'h33,       32'h12345678, 0, 0, 1, 32'h33,       0};

    // Every address reads zero and not busy on both ports while held in reset.
    #2;
    for (int a = 0; a < 32; a++) begin
      rs1_reg = 5'(a);
      rs2_reg = 5'(31 - a);
      #1;
      check($sformatf("reset_read_a%0d", a), {d1 | d2 | d1_nb, 7'b0, b1, b2, b1_nb, b2_nb, err},
            32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 18; v++) begin
      drive(vecs[v].rs1, vecs[v].rs2, vecs[v].iss_en, vecs[v].iss_reg,
            vecs[v].wb_en, vecs[v].wb_reg, vecs[v].wb_data);
      check($sformatf("v%0d_rs1_data", v),    d1,          vecs[v].e_d1);
      check($sformatf("v%0d_rs2_data", v),    d2,          vecs[v].e_d2);
      check($sformatf("v%0d_rs1_busy", v),    32'(b1),     32'(vecs[v].e_b1));
      check($sformatf("v%0d_rs2_busy", v),    32'(b2),     32'(vecs[v].e_b2));
      check($sformatf("v%0d_sb_err", v),      32'(err),    32'(vecs[v].e_err));
      check($sformatf("v%0d_nb_rs1_data", v), d1_nb,       vecs[v].e_d1_nb);
      check($sformatf("v%0d_nb_rs1_busy", v), 32'(b1_nb),  32'(vecs[v].e_b1_nb));
    end

    // Asynchronous reset in the middle of a cycle wipes array contents and the sticky error.
    drive(0, 0, 1, 5, 0, 0, 32'h0);
    drive(0, 0, 0, 0, 1, 5, 32'hDEADBEEF);
    drive(5, 5, 0, 0, 0, 0, 32'h0);
    check("midrst_pre_x5", d1, 32'hDEADBEEF);
    check("midrst_pre_err", 32'(err), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_x5_rs1", d1, 32'h0);
    check("midrst_x5_rs2", d2_nb, 32'h0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_busy", {30'b0, b1, b2}, 32'h0);
    #2;
    rst_n = 1'b1;

    // Four issues to x4 saturate its counter at 3 and raise the error.
    drive(4, 0, 1, 4, 0, 0, 32'h0);
    check("sat_iss1_busy", 32'(b1), 32'd0);
    drive(4, 0, 1, 4, 0, 0, 32'h0);
    drive(4, 0, 1, 4, 0, 0, 32'h0);
    drive(4, 0, 1, 4, 0, 0, 32'h0);
    check("sat_cnt3_busy", 32'(b1), 32'd1);
    check("sat_cnt3_err", 32'(err), 32'd0);
    drive(4, 0, 0, 0, 0, 0, 32'h0);
    check("sat_over_err", 32'(err), 32'd1);
    check("sat_over_busy", 32'(b1), 32'd1);
    drive(4, 0, 0, 0, 1, 4, 32'h1);
    check("sat_wb1_busy", 32'(b1), 32'd1);
    drive(4, 0, 0, 0, 1, 4, 32'h2);
    check("sat_wb2_busy", 32'(b1), 32'd1);
    drive(4, 0, 0, 0, 1, 4, 32'h3);
    check("sat_wb3_busy", 32'(b1), 32'd0);
    check("sat_wb3_data", d1, 32'h3);
    drive(4, 0, 0, 0, 0, 0, 32'h0);
    check("sat_drained_busy", 32'(b1), 32'd0);
    check("sat_err_sticky", 32'(err), 32'd1);
    check("sat_final_data", d1, 32'h3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
